fir_mac_controller: RTL and testbench

Sequencer and accumulator for the time-multiplexed FIR datapath. It accepts one input sample per handshake and pulses the delay-line shift. It then steps tap_index from 0 to K-1 to drive the sample mux and coefficient ROM, and multiply-accumulates the returned operand pairs. Each result is rounded and saturated, then presented on a valid/ready output handshake. It sits between the upstream sample source, the delay line/sample selector/coefficient ROM, and the downstream consumer.

---
 rtl/fir_mac_controller.sv | 121 ++++++++++++
 tb/tb_fir_mac_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_controller.sv
// ============================================================================
// Module   : fir_mac_controller
// Purpose  : Sequencer and rounding/saturating MAC for a time-multiplexed FIR
// Revision : 1.0
// ============================================================================
`default_nettype none

module fir_mac_controller #(
    parameter int DATA_WIDTH = 16,
    parameter int K          = 8,
    parameter int FRAC_BITS  = 15,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(K)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   shift_en,
    output logic [$clog2(K)-1:0]   tap_index,
    output logic [$clog2(K)-1:0]   coef_addr,
    input  logic [DATA_WIDTH-1:0]  sample_sel,
    input  logic [DATA_WIDTH-1:0]  coef_in,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  y_out
);

    localparam int                 TW       = $clog2(K);
    localparam int                 PW       = 2*DATA_WIDTH;
    localparam logic [TW-1:0]      C_LAST   = TW'(K-1);
    localparam logic [ACC_WIDTH:0] C_RND    = {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_BITS-1);
    localparam logic signed [ACC_WIDTH:0] C_MAX =
        $signed({{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH:0] C_MIN =
        $signed({{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}});

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MAC   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [TW-1:0]                 r_tap;
    logic                          r_in_ready;
    logic [DATA_WIDTH-1:0]         r_y;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic signed [ACC_WIDTH-1:0]   w_acc_next;
    logic signed [PW-1:0]          w_prod;
    logic signed [ACC_WIDTH-1:0]   w_prod_ext;
    logic signed [ACC_WIDTH:0]     w_rnd;
    logic signed [ACC_WIDTH:0]     w_shifted;
    logic [DATA_WIDTH-1:0]         w_sat;
    logic                          w_last_tap;

    assign w_prod     = $signed(sample_sel) * $signed(coef_in);
    assign w_prod_ext = {{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod};
    assign w_acc_next = (r_tap == '0) ? w_prod_ext : r_acc + w_prod_ext;
    assign w_last_tap = (r_state == S_MAC) && (r_tap == C_LAST);

    // One guard bit above the accumulator so adding the rounding constant cannot wrap.
    assign w_rnd      = $signed({w_acc_next[ACC_WIDTH-1], w_acc_next} + C_RND);
    assign w_shifted  = w_rnd >>> FRAC_BITS;

    always_comb begin
        w_sat = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted > C_MAX) begin
            w_sat = C_MAX[DATA_WIDTH-1:0];
        end else if (w_shifted < C_MIN) begin
            w_sat = C_MIN[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)   w_next = S_SHIFT;
            S_SHIFT:                 w_next = S_MAC;
            S_MAC:   if (w_last_tap) w_next = S_DONE;
            S_DONE:  if (out_ready)  w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    // in_ready is registered so it stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_tap      <= '0;
            r_acc      <= '0;
            r_y        <= '0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == S_IDLE);
            if (r_state == S_MAC) begin
                r_acc <= w_acc_next;
                r_tap <= w_last_tap ? '0 : r_tap + TW'(1);
            end else begin
                r_tap <= '0;
            end
            if (w_last_tap) begin
                r_y <= w_sat;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign shift_en  = (r_state == S_SHIFT);
    assign busy      = (r_state == S_SHIFT) || (r_state == S_MAC);
    assign out_valid = (r_state == S_DONE);
    assign tap_index = r_tap;
    assign coef_addr = r_tap;
    assign y_out     = r_y;

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_controller.sv
// ============================================================================
// Module   : tb_fir_mac_controller
// Purpose  : Self-checking bench with delay-line/ROM model and scoreboard
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fir_mac_controller;

    localparam int DW = 16;
    localparam int K  = 8;
    localparam int FB = 15;
    localparam int TW = $clog2(K);

    typedef logic signed [DW-1:0] vec_t [K];
    typedef struct {
        vec_t   taps;
        vec_t   coefs;
        longint y;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          shift_en;
    logic [TW-1:0] tap_index;
    logic [TW-1:0] coef_addr;
    logic [DW-1:0] sample_sel;
    logic [DW-1:0] coef_in;
    logic          busy;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] y_out;

    logic [DW-1:0]        in_data = '0;
    logic signed [DW-1:0] pending;
    vec_t                 dl;
    vec_t                 coef;
    vec_t                 preload_vec;
    logic                 preload = 1'b0;

    int     n_checks  = 0;
    int     n_fail    = 0;
    int     shift_cnt = 0;
    int     addr_mis  = 0;
    int     cyc       = 0;
    longint exp_q[$];
    int     tap_log[$];
    rec_t   tbl[5];

    fir_mac_controller #(.DATA_WIDTH(DW), .K(K), .FRAC_BITS(FB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .shift_en   (shift_en),
        .tap_index  (tap_index),
        .coef_addr  (coef_addr),
        .sample_sel (sample_sel),
        .coef_in    (coef_in),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y_out      (y_out)
    );

    always #5 clk = ~clk;

    assign sample_sel = dl[tap_index];
    assign coef_in    = coef[coef_addr];

    function automatic vec_t shifted(vec_t d, logic signed [DW-1:0] s);
        vec_t r;
        r[0] = s;
        for (int i = 1; i < K; i++) r[i] = d[i-1];
        return r;
    endfunction

    // Filter output straight from the arithmetic definition.
    function automatic longint ref_y(vec_t s, vec_t c);
        longint acc = 0;
        longint hi  = (longint'(1) <<< (DW-1)) - 1;
        longint lo  = -(longint'(1) <<< (DW-1));
        for (int i = 0; i < K; i++) acc += longint'(s[i]) * longint'(c[i]);
        acc = (acc + (longint'(1) <<< (FB-1))) >>> FB;
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
        return acc;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (coef_addr != tap_index) addr_mis <= addr_mis + 1;
        if (in_valid && in_ready) pending <= in_data;
        if (busy && !shift_en) tap_log.push_back(int'(tap_index));
        if (preload) begin
            dl <= preload_vec;
        end else if (shift_en) begin
            dl        <= shifted(dl, pending);
            exp_q.push_back(ref_y(shifted(dl, pending), coef));
            shift_cnt <= shift_cnt + 1;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_y(input bit use_tbl, input longint tbl_y);
        longint e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check("y_model", longint'($signed(y_out)), e);
        end
        if (use_tbl) check("y_table", longint'($signed(y_out)), tbl_y);
    endtask

    task automatic load(input vec_t taps_after, input vec_t c, output logic [DW-1:0] s);
        for (int i = 0; i < K-1; i++) preload_vec[i] = taps_after[i+1];
        preload_vec[K-1] = '0;
        coef    = c;
        s       = taps_after[0];
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
    endtask

    task automatic rand_vec(output vec_t v);
        for (int i = 0; i < K; i++) v[i] = DW'($urandom);
    endtask

    task automatic accept(input logic [DW-1:0] s);
        int n = 0;
        in_data  = s;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 60) begin @(posedge clk); #1; n++; end
        if (!out_valid) check("out_valid_timeout", 0, 1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    task automatic run_txn(input logic [DW-1:0] s, input bit use_tbl, input longint tbl_y);
        int sc0;
        int lat;
        sc0 = shift_cnt;
        accept(s);
        wait_out(lat);
        check("latency", lat, K+1);
        check_y(use_tbl, tbl_y);
        check("shift_pulses", shift_cnt - sc0, 1);
        release_out();
    endtask

    initial begin
        logic [DW-1:0] s;
        vec_t   v, c;
        int     n, sc0, bad;
        longint y0;
        int     outs[$];

        for (int i = 0; i < K; i++) begin
            tbl[0].taps[i] = DW'(10*(i+1));  tbl[0].coefs[i] = 16'sh4000;
            tbl[1].taps[i] = (i == 3) ? 16'sd1 : 16'sd0; tbl[1].coefs[i] = 16'sh4000;
            tbl[2].taps[i] = (i == 3) ? 16'sd1 : 16'sd0; tbl[2].coefs[i] = 16'sh3FFF;
            tbl[3].taps[i] = 16'sh7FFF;      tbl[3].coefs[i] = 16'sh7FFF;
            tbl[4].taps[i] = 16'sh8000;      tbl[4].coefs[i] = 16'sh7FFF;
        end
        tbl[0].y = 180;  tbl[1].y = 1;  tbl[2].y = 0;
        tbl[3].y = 32767; tbl[4].y = -32768;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_shift_en", shift_en, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_tap_index", tap_index, 0);
        check("rst_y_out", y_out, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_release", in_ready, 1);

        for (int t = 0; t < 5; t++) begin
            load(tbl[t].taps, tbl[t].coefs, s);
            run_txn(s, 1'b1, tbl[t].y);
        end

        for (int t = 0; t < 10; t++) begin
            rand_vec(v);
            rand_vec(c);
            load(v, c, s);
            run_txn(s, 1'b0, 0);
        end

        // Backpressure: result must hold while downstream stalls.
        rand_vec(v); rand_vec(c);
        load(v, c, s);
        accept(s);
        wait_out(n);
        y0  = longint'(y_out);
        sc0 = shift_cnt;
        bad = 0;
        repeat (20) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (!out_valid || longint'(y_out) != y0 || in_ready) bad++;
        end
        in_valid = 1'b0;
        check("bp_stable", bad, 0);
        check("bp_no_shift", shift_cnt - sc0, 0);
        check_y(1'b0, 0);
        release_out();

        // Streaming: both handshakes held high.
        rand_vec(c);
        coef = c;
        tap_log.delete();
        sc0 = shift_cnt;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (outs.size() < 5 && n < 200) begin
            @(posedge clk); #1;
            in_data = DW'($urandom);
            n++;
            if (out_valid) begin
                outs.push_back(cyc);
                check_y(1'b0, 0);
                if (outs.size() == 5) in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stream_outputs", outs.size(), 5);
        for (int i = 1; i < outs.size(); i++) check("stream_spacing", outs[i] - outs[i-1], K+3);
        check("stream_shifts", shift_cnt - sc0, 5);
        check("stream_tap_count", tap_log.size(), 5*K);
        bad = 0;
        for (int i = 0; i < tap_log.size(); i++) if (tap_log[i] != i % K) bad++;
        check("stream_tap_seq", bad, 0);

        // Reset in the middle of accumulation.
        rand_vec(v); rand_vec(c);
        load(v, c, s);
        accept(s);
        n = 0;
        while (tap_index != TW'(4) && n < 30) begin @(posedge clk); #1; n++; end
        check("reached_tap4", tap_index, 4);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 0);
        check("abort_shift_en", shift_en, 0);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_tap_index", tap_index, 0);
        check("abort_y_out", y_out, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (15) begin @(posedge clk); #1; if (out_valid) bad++; end
        check("abort_no_output", bad, 0);
        rand_vec(v); rand_vec(c);
        load(v, c, s);
        run_txn(s, 1'b0, 0);

        check("coef_addr_tracks_tap", addr_mis, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
